// File: rtl/i_slicer_pkg.sv
// Shared types and constants for the I-rail 4-ASK slicer.
package i_slicer_pkg;

  localparam int DATA_W = 18;

  // Gray-coded symbol values, ordered from most negative to most positive level
  localparam logic [1:0] SYM_M3 = 2'b00;
  localparam logic [1:0] SYM_M1 = 2'b01;
  localparam logic [1:0] SYM_P1 = 2'b11;
  localparam logic [1:0] SYM_P3 = 2'b10;

  // 0.25 in 1s17
  localparam logic signed [DATA_W-1:0] INIT_REF_DEFAULT = 18'sh08000;

  localparam logic signed [DATA_W-1:0] SAT_MAX = 18'sh1FFFF;
  localparam logic signed [DATA_W-1:0] SAT_MIN = 18'sh20000;

  typedef enum logic {
    ACQ   = 1'b0,
    TRACK = 1'b1
  } slicer_state_e;

  // Magnitude of a 1s17 sample; the most negative code clips to the largest magnitude
  function automatic logic [DATA_W-2:0] abs_sat(input logic signed [DATA_W-1:0] x);
    logic signed [DATA_W-1:0] neg;
    if (x == SAT_MIN) begin
      abs_sat = {(DATA_W-1){1'b1}};
    end else if (x[DATA_W-1]) begin
      neg     = -x;
      abs_sat = neg[DATA_W-2:0];
    end else begin
      abs_sat = x[DATA_W-2:0];
    end
  endfunction

endpackage

// File: rtl/i_slicer_ask4_slicer.sv
// Combinational 4-ASK decision: Gray symbol, decided level and saturated error.
module ask4_slicer
  import i_slicer_pkg::*;
(
  input  logic signed [DATA_W-1:0] x,
  input  logic signed [DATA_W-1:0] a,
  output logic        [1:0]        sym,
  output logic signed [DATA_W-1:0] dec,
  output logic signed [DATA_W-1:0] err
);

  localparam logic signed [DATA_W:0] ERR_HI = 19'sd131071;
  localparam logic signed [DATA_W:0] ERR_LO = -19'sd131072;

  logic signed [DATA_W:0]   a3_wide;
  logic signed [DATA_W-1:0] a3;
  logic signed [DATA_W+1:0] two_a;
  logic signed [DATA_W+1:0] x_ext;
  logic signed [DATA_W:0]   diff;

  // Outer level 3a, clipped so it stays representable in 1s17
  always_comb begin
    a3_wide = $signed({a[DATA_W-1], a}) + $signed({a[DATA_W-1], a} <<< 1);
    if (a3_wide > $signed({1'b0, SAT_MAX})) begin
      a3 = SAT_MAX;
    end else begin
      a3 = a3_wide[DATA_W-1:0];
    end
  end

  // Threshold compare against 0 and +/-2a in 20 bits so 2a never wraps
  always_comb begin
    two_a = $signed({a[DATA_W-1], a[DATA_W-1], a}) <<< 1;
    x_ext = $signed({x[DATA_W-1], x[DATA_W-1], x});
    if (x_ext < -two_a) begin
      sym = SYM_M3;
      dec = -a3;
    end else if (x_ext < 0) begin
      sym = SYM_M1;
      dec = -a;
    end else if (x_ext < two_a) begin
      sym = SYM_P1;
      dec = a;
    end else begin
      sym = SYM_P3;
      dec = a3;
    end
  end

  // Slicing error x - dec, clipped back into 1s17
  always_comb begin
    diff = $signed({x[DATA_W-1], x}) - $signed({dec[DATA_W-1], dec});
    if (diff > ERR_HI) begin
      err = SAT_MAX;
    end else if (diff < ERR_LO) begin
      err = SAT_MIN;
    end else begin
      err = diff[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/i_slicer.sv
// I-rail 4-ASK slicer with windowed reference adaptation and MSE measurement.
//
// state | meaning
// ------+---------------------------------------------------------------
// ACQ   | no window has completed yet; reference is still INIT_REF
// TRACK | at least one window completed; reference follows mean |x| / 2
module i_slicer
  import i_slicer_pkg::*;
#(
  parameter int                       LOG2_N   = 10,
  parameter logic signed [DATA_W-1:0] INIT_REF = INIT_REF_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     sym_clk,
  input  logic                     clear_accum,
  input  logic signed [DATA_W-1:0] data_in,
  output logic        [1:0]        sym_out,
  output logic signed [DATA_W-1:0] dec_out,
  output logic signed [DATA_W-1:0] err_out,
  output logic signed [DATA_W-1:0] ref_level,
  output logic        [DATA_W-1:0] err_power,
  output logic                     meas_valid,
  output logic                     locked
);

  localparam int ABS_W = DATA_W - 1 + LOG2_N;
  localparam int ERR_W = DATA_W + LOG2_N;

  logic        [1:0]        s_sym;
  logic signed [DATA_W-1:0] s_dec;
  logic signed [DATA_W-1:0] s_err;

  logic        [LOG2_N-1:0] cnt;
  logic        [ABS_W-1:0]  abs_acc;
  logic        [ERR_W-1:0]  err_acc;
  slicer_state_e            state;

  logic        [DATA_W-2:0] x_abs;
  logic signed [35:0]       err_sq;
  logic        [DATA_W-1:0] err_sq_q;
  logic        [ABS_W-1:0]  abs_sum;
  logic        [ERR_W-1:0]  err_sum;
  logic                     win_end;

  ask4_slicer u_slicer (
    .x   (data_in),
    .a   (ref_level),
    .sym (s_sym),
    .dec (s_dec),
    .err (s_err)
  );

  // Per-symbol contributions and the running sums including the current symbol
  always_comb begin
    x_abs    = abs_sat(data_in);
    err_sq   = 36'(s_err) * 36'(s_err);
    err_sq_q = 18'(err_sq >> 17);
    abs_sum  = abs_acc + ABS_W'(x_abs);
    err_sum  = err_acc + ERR_W'(err_sq_q);
    win_end  = sym_clk && !clear_accum && (cnt == '1);
  end

  // Decision output registers, loaded once per symbol
  always_ff @(posedge clk) begin
    if (reset) begin
      sym_out <= '0;
      dec_out <= '0;
      err_out <= '0;
    end else if (sym_clk) begin
      sym_out <= s_sym;
      dec_out <= s_dec;
      err_out <= s_err;
    end
  end

  // Window accumulation; publishes reference and error power at window end
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      abs_acc    <= '0;
      err_acc    <= '0;
      ref_level  <= INIT_REF;
      err_power  <= '0;
      meas_valid <= 1'b0;
    end else begin
      meas_valid <= win_end;
      if (clear_accum) begin
        cnt     <= '0;
        abs_acc <= '0;
        err_acc <= '0;
      end else if (sym_clk) begin
        if (cnt == '1) begin
          cnt       <= '0;
          abs_acc   <= '0;
          err_acc   <= '0;
          ref_level <= $signed(18'(abs_sum >> (LOG2_N + 1)));
          err_power <= 18'(err_sum >> LOG2_N);
        end else begin
          cnt     <= cnt + LOG2_N'(1);
          abs_acc <= abs_sum;
          err_acc <= err_sum;
        end
      end
    end
  end

  // Lock FSM: leaves ACQ on the first completed window, only reset returns it
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ACQ;
      locked <= 1'b0;
    end else begin
      case (state)
        ACQ: begin
          if (win_end) begin
            state  <= TRACK;
            locked <= 1'b1;
          end
        end
        TRACK: begin
          locked <= 1'b1;
        end
        default: begin
          state  <= ACQ;
          locked <= 1'b0;
        end
      endcase
    end
  end

endmodule
